bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using iterative double-dabble (shift-and-add-3), one bit per clock. It replaces the fixed-width combinational digit conversion used by the digital clock display path. One instance serves any field width, from 6-bit seconds to 14-bit year. It adds a start/busy/done handshake, overflow detection when the value does not fit in DIGITS, and optional saturation.

## Interface
- WIDTH, 14: binary input width; legal range ≥1.
- DIGITS, 5: number of BCD output digits; legal range ≥1.
- SAT, 1: 1 = on overflow `bcd` shows all nines; 0 = `bcd` shows the low DIGITS digits (wrapped).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when `busy`=0.
- bin  input  WIDTH  unsigned binary value; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; `bcd` and `ovf` are valid from this cycle on.
- bcd  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], digit 0 is the units digit.
- ovf  output  1  result did not fit: `bin` ≥ 10^DIGITS.

## Operation
- States:
  - IDLE: `busy`=0.
  - CONV: `busy`=1; an internal counter `cnt` runs 0..WIDTH-1.
- IDLE→CONV: on an edge with `start`=1 and `busy`=0:
  - latch `bin` into shift register `sr`;
  - clear the BCD accumulator `acc` (4*DIGITS bits) and the overflow accumulator `ov_acc`;
  - set `cnt`=0.
- Each edge in CONV performs one double-dabble step:
  - for every digit of `acc` that is ≥5, add 3 (all digits adjusted in parallel);
  - shift {`acc`, `sr`} left by 1;
  - OR the bit shifted out of the top of `acc` into `ov_acc`;
  - increment `cnt`.
- CONV→IDLE: on the edge where `cnt`=WIDTH-1:
  - load `bcd` with the post-step accumulator value;
  - load `ovf` with the final `ov_acc`, including that edge's shifted-out bit;
  - if SAT=1 and `ovf`, load `bcd` with all digits = 9;
  - `busy`←0, `done`←1.
- `done` returns to 0 on the following edge unless a new conversion completes on it. A new conversion cannot complete on the next edge when WIDTH>1.
- `bcd` and `ovf` are output registers separate from `acc`. They hold the previous result, unchanged, throughout a conversion and update only at completion.
- Overflow detection: a 1 bit leaves the top digit if and only if `bin` ≥ 10^DIGITS. No separate comparator is used.
- DIGITS may exceed what WIDTH needs; the unused upper digits read 0.

## Timing
- Reset (synchronous): the state goes to IDLE, any conversion in progress is aborted and discarded, and all outputs are 0:
  - `busy`=0, `done`=0, `bcd`=0, `ovf`=0.
- Latency: `start` accepted at edge E0 gives `done`=1 and a valid `bcd` after edge E0+WIDTH, i.e. WIDTH cycles.
- `busy` is high from after E0 until after E0+WIDTH.
- Throughput: one conversion per WIDTH+1 cycles.
  - `start` may be held high or re-asserted in the cycle in which `done`=1. It is accepted there because `busy`=0.
- `start` while `busy`=1 is ignored. `bin` changes during CONV have no effect.
- `rst` and `start` high on the same edge: reset wins and nothing is accepted.
- WIDTH=1: CONV lasts exactly one edge (E0+1).

## Test plan
- WIDTH=14, DIGITS=5, `bin`=16383, pulse `start` → `busy` high for 14 cycles, `done` pulses once 14 cycles after acceptance, `bcd`=20'h16383, `ovf`=0. Then `bin`=0 → `bcd`=20'h00000.
- WIDTH=6, DIGITS=2 (seconds field):
  - `bin`=59 → `bcd`=8'h59 after 6 cycles;
  - `bin`=63 → `bcd`=8'h63, `ovf`=0.
- WIDTH=14, DIGITS=4:
  - `bin`=9999 → `bcd`=16'h9999, `ovf`=0;
  - `bin`=10000 with SAT=1 → `bcd`=16'h9999, `ovf`=1;
  - `bin`=10000 with SAT=0 → `bcd`=16'h0000, `ovf`=1;
  - `bin`=12345 with SAT=0 → `bcd`=16'h2345, `ovf`=1.
- Handshake:
  - start 100, then pulse `start` with `bin`=200 in the 5th busy cycle → ignored, result 100, a single `done` pulse;
  - hold `start` high continuously → results complete every WIDTH+1 cycles;
  - `bcd` stays stable during each conversion.
- Reset mid-conversion: assert `rst` in busy cycle 7 → next cycle `busy`=0 and `bcd`=0, and no `done` follows. Then `start` with `bin`=42 → `bcd`=20'h00042 after 14 cycles.
- Random: 700 random `bin` values at WIDTH=14, DIGITS=5, issued back-to-back → each `bcd` equals a model's decimal digits of `bin`, and `ovf`=0 throughout.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5,
    parameter int SAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);
    localparam int AW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [AW-1:0]    acc, acc_adj, acc_step;
    logic             ov_acc, ov_step;
    logic [CW-1:0]    cnt;
    logic             last, accept, finish;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == CONV);
        accept = (state == IDLE) && start;
        finish = (state == CONV) && last;
    end

    // Add-3 on every digit >= 5 before the shift; bits leaving the top digit mark overflow.
    always_comb begin
        last = (cnt == CW'(WIDTH - 1));
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
        acc_step = {acc_adj[AW-2:0], sr[WIDTH-1]};
        ov_step  = ov_acc | acc_adj[AW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            acc    <= '0;
            ov_acc <= 1'b0;
            cnt    <= '0;
            bcd    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                sr     <= bin;
                acc    <= '0;
                ov_acc <= 1'b0;
                cnt    <= '0;
            end else if (busy) begin
                sr     <= sr << 1;
                acc    <= acc_step;
                ov_acc <= ov_step;
                cnt    <= cnt + CW'(1);
            end
            if (finish) begin
                ovf <= ov_step;
                bcd <= ((SAT != 0) && ov_step) ? {DIGITS{4'h9}} : acc_step;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq across four field configurations
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_v [4];
    logic [13:0] bin_v   [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        ovf_v   [4];
    logic [19:0] bcd0;
    logic [7:0]  bcd1;
    logic [15:0] bcd2, bcd3;
    logic [19:0] bcd_x   [4];

    always_comb begin
        bcd_x[0] = bcd0;
        bcd_x[1] = {12'h000, bcd1};
        bcd_x[2] = {4'h0, bcd2};
        bcd_x[3] = {4'h0, bcd3};
    end

    bin2bcd_seq #(.WIDTH(14), .DIGITS(5), .SAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .ovf(ovf_v[0]));
    bin2bcd_seq #(.WIDTH(6), .DIGITS(2), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bin(bin_v[1][5:0]),
        .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .ovf(ovf_v[1]));
    bin2bcd_seq #(.WIDTH(14), .DIGITS(4), .SAT(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .bin(bin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .ovf(ovf_v[2]));
    bin2bcd_seq #(.WIDTH(14), .DIGITS(4), .SAT(0)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .bin(bin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .bcd(bcd3), .ovf(ovf_v[3]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] model(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic conv(input int k, input logic [13:0] v,
                        output logic [19:0] r, output logic o, output int lat);
        @(negedge clk);
        bin_v[k]   = v;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        lat = 0;
        while (done_v[k] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = bcd_x[k];
        o = ovf_v[k];
    endtask

    typedef struct {
        int          k;
        logic [13:0] v;
        logic [19:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [11];
    int   exp_lat [4] = '{14, 6, 14, 14};

    initial begin
        logic [19:0] r;
        logic        o;
        int          lat, dones, done_at, unstable, busy_cnt, nd;
        int          dt [3];
        int          vals [700];

        vecs[0]  = '{0, 14'd16383, 20'h16383, 1'b0};
        vecs[1]  = '{0, 14'd0,     20'h00000, 1'b0};
        vecs[2]  = '{1, 14'd59,    20'h00059, 1'b0};
        vecs[3]  = '{1, 14'd63,    20'h00063, 1'b0};
        vecs[4]  = '{1, 14'd0,     20'h00000, 1'b0};
        vecs[5]  = '{2, 14'd9999,  20'h09999, 1'b0};
        vecs[6]  = '{2, 14'd10000, 20'h09999, 1'b1};
        vecs[7]  = '{3, 14'd10000, 20'h00000, 1'b1};
        vecs[8]  = '{3, 14'd12345, 20'h02345, 1'b1};
        vecs[9]  = '{3, 14'd9999,  20'h09999, 1'b0};
        vecs[10] = '{0, 14'd9999,  20'h09999, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            bin_v[k]   = '0;
        end
        repeat (3) @(posedge clk);
        // Reset and start together on the last reset edge: nothing may be accepted.
        #1 start_v[0] = 1'b1;
        bin_v[0] = 14'd77;
        @(posedge clk); #1;
        rst = 1'b0;
        start_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_busy%0d", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset_done%0d", k), 32'(done_v[k]), 32'd0);
            check($sformatf("reset_bcd%0d", k),  32'(bcd_x[k]),  32'd0);
            check($sformatf("reset_ovf%0d", k),  32'(ovf_v[k]),  32'd0);
        end

        foreach (vecs[i]) begin
            conv(vecs[i].k, vecs[i].v, r, o, lat);
            check($sformatf("vec%0d_bcd", i), 32'(r), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat[vecs[i].k]));
        end

        // Start during busy is ignored; bcd holds the previous result meanwhile.
        @(negedge clk);
        bin_v[0] = 14'd100;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check("ign_busy_after_e0", 32'(busy_v[0]), 32'd1);
        busy_cnt = 1; dones = 0; done_at = -1; unstable = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin start_v[0] = 1'b1; bin_v[0] = 14'd200; end
            if (c == 6) start_v[0] = 1'b0;
            @(posedge clk); #1;
            if (busy_v[0]) busy_cnt++;
            if (done_v[0]) begin dones++; done_at = c; end
            if (c < 14 && bcd_x[0] !== 20'h09999) unstable++;
        end
        check("ign_dones", 32'(dones), 32'd1);
        check("ign_done_at", 32'(done_at), 32'd14);
        check("ign_busy_cycles", 32'(busy_cnt), 32'd14);
        check("ign_bcd_stable", 32'(unstable), 32'd0);
        check("ign_bcd", 32'(bcd_x[0]), 32'h00100);

        // Start held high: one completion every WIDTH+1 cycles.
        @(negedge clk);
        bin_v[0] = 14'd1234;
        start_v[0] = 1'b1;
        nd = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (done_v[0] && nd < 3) begin dt[nd] = c; nd++; end
        end
        start_v[0] = 1'b0;
        check("hold_ndone", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("hold_first", 32'(dt[0]), 32'd15);
            check("hold_gap1", 32'(dt[1] - dt[0]), 32'd15);
            check("hold_gap2", 32'(dt[2] - dt[1]), 32'd15);
        end
        check("hold_bcd", 32'(bcd_x[0]), 32'h01234);
        lat = 0;
        while (busy_v[0] && lat < 40) begin @(posedge clk); #1; lat++; end
        check("hold_drain", 32'(busy_v[0]), 32'd0);

        // Reset in the 7th busy cycle aborts the conversion.
        @(negedge clk);
        bin_v[0] = 14'd777;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_busy", 32'(busy_v[0]), 32'd0);
        check("rstmid_bcd", 32'(bcd_x[0]), 32'd0);
        check("rstmid_ovf", 32'(ovf_v[0]), 32'd0);
        dones = 0;
        repeat (20) begin @(posedge clk); #1; if (done_v[0]) dones++; end
        check("rstmid_nodone", 32'(dones), 32'd0);
        conv(0, 14'd42, r, o, lat);
        check("rstmid_bcd42", 32'(r), 32'h00042);
        check("rstmid_lat42", 32'(lat), 32'd14);

        // Back-to-back random conversions, start held high throughout.
        foreach (vals[i]) vals[i] = int'($urandom_range(0, 16383));
        @(negedge clk);
        bin_v[0] = 14'(vals[0]);
        start_v[0] = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            if (i < 699) bin_v[0] = 14'(vals[i+1]);
            else         start_v[0] = 1'b0;
            lat = 0;
            while (done_v[0] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
            check($sformatf("rnd%0d_bcd", i), 32'(bcd_x[0]), 32'(model(vals[i])));
            check($sformatf("rnd%0d_ovf", i), 32'(ovf_v[0]), 32'd0);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd14);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
